// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// fir_pkg : shared FSM encoding, default widths and helpers for fir_ch_sched
// Rev 1.0
// ============================================================================
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int c_dw_def  = 16;
  localparam int c_tmo_def = 2048;

  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin grant, searching upward from last+1
// Rev 1.0
// ============================================================================
module rr_arbiter
  import fir_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = chw(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  last,
  input  logic           en,
  output logic [NCH-1:0] gnt,
  output logic [CW-1:0]  gnt_id,
  output logic           any
);

  logic [CW-1:0] w_idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    w_idx  = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_idx = CW'((int'(last) + k) % NCH);
      if (en && !any && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        gnt_id     = w_idx;
        any        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_ch_sched.sv
`default_nettype none
// ============================================================================
// fir_ch_sched : shares one multi-cycle FIR engine among NCH sample channels
// Rev 1.0
// ============================================================================
module fir_ch_sched
  import fir_pkg::*;
#(
  parameter int DW  = c_dw_def,
  parameter int NCH = 4,
  parameter int CW  = chw(NCH),
  parameter int TMO = c_tmo_def
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic [NCH*DW-1:0] s_tdata,
  input  logic [NCH-1:0]    s_tvalid,
  output logic [NCH-1:0]    s_tready,
  output logic [DW-1:0]     eng_tdata,
  output logic              eng_tvalid,
  input  logic              eng_tready,
  output logic [CW-1:0]     eng_sel,
  input  logic [DW-1:0]     eng_rdata,
  input  logic              eng_rvalid,
  output logic [DW-1:0]     m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [CW-1:0]     m_tdest,
  input  logic              err_clr,
  output logic              err_tmo,
  output logic              err_spur,
  output logic              busy
);

  localparam int TW = $clog2(TMO + 1);

  state_t         r_state;
  logic [CW-1:0]  r_last;
  logic [TW-1:0]  r_cnt;

  logic [DW-1:0]  w_ch [NCH];
  logic [NCH-1:0] w_gnt;
  logic [CW-1:0]  w_gnt_id;
  logic           w_any;
  logic           w_arb_en;
  logic           w_tmo_hit;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign w_ch[i] = s_tdata[i*DW +: DW];
  end

  assign w_arb_en  = ce && (r_state == IDLE);
  assign w_tmo_hit = (r_cnt == TW'(TMO - 1));
  assign s_tready  = w_gnt;

  rr_arbiter #(
    .NCH (NCH),
    .CW  (CW)
  ) u_arb (
    .req    (s_tvalid),
    .last   (r_last),
    .en     (w_arb_en),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id),
    .any    (w_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_last     <= CW'(NCH - 1);
      r_cnt      <= '0;
      eng_tdata  <= '0;
      eng_tvalid <= 1'b0;
      eng_sel    <= '0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tdest    <= '0;
      err_tmo    <= 1'b0;
      err_spur   <= 1'b0;
      busy       <= 1'b0;
    end else if (ce) begin
      // Sticky bits: a set later in this block overrides the clear.
      err_tmo  <= err_tmo & ~err_clr;
      err_spur <= (err_spur & ~err_clr) | (eng_rvalid && (r_state != WAIT));
      case (r_state)
        IDLE: begin
          if (w_any) begin
            eng_tdata  <= w_ch[w_gnt_id];
            eng_sel    <= w_gnt_id;
            m_tdest    <= w_gnt_id;
            eng_tvalid <= 1'b1;
            busy       <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (eng_tready) begin
            eng_tvalid <= 1'b0;
            r_cnt      <= '0;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (eng_rvalid) begin
            m_tdata  <= eng_rdata;
            m_tvalid <= 1'b1;
            r_state  <= OUT;
          end else if (w_tmo_hit) begin
            err_tmo <= 1'b1;
            r_last  <= eng_sel;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + TW'(1);
          end
        end
        OUT: begin
          if (m_tready) begin
            m_tvalid <= 1'b0;
            r_last   <= m_tdest;
            busy     <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_ch_sched.sv
`default_nettype none
// ============================================================================
// tb_fir_ch_sched : scoreboard bench for fir_ch_sched with an echoing engine
// Rev 1.0
// ============================================================================
module tb_fir_ch_sched;

  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int TMO = 2048;

  logic              clk;
  logic              reset_n;
  logic              ce;
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH-1:0]    s_tvalid;
  logic [NCH-1:0]    s_tready;
  logic [DW-1:0]     eng_tdata;
  logic              eng_tvalid;
  logic              eng_tready;
  logic [CW-1:0]     eng_sel;
  logic [DW-1:0]     eng_rdata;
  logic              eng_rvalid;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic [CW-1:0]     m_tdest;
  logic              err_clr;
  logic              err_tmo;
  logic              err_spur;
  logic              busy;

  fir_ch_sched #(
    .DW  (DW),
    .NCH (NCH),
    .CW  (CW),
    .TMO (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .eng_tdata  (eng_tdata),
    .eng_tvalid (eng_tvalid),
    .eng_tready (eng_tready),
    .eng_sel    (eng_sel),
    .eng_rdata  (eng_rdata),
    .eng_rvalid (eng_rvalid),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdest    (m_tdest),
    .err_clr    (err_clr),
    .err_tmo    (err_tmo),
    .err_spur   (err_spur),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [CW+DW-1:0] out_q [$];
  int               grant_q [$];
  bit               eng_mute = 1'b0;
  int               spur_req = 0;
  int               spur_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int ch, input logic [DW-1:0] data);
    grant_q.push_back(ch);
    out_q.push_back({CW'(ch), data});
  endtask

  task automatic wait_grants(input int budget);
    int n;
    n = 0;
    while (grant_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("grant_wait", grant_q.size(), 0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((out_q.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    check("drain_q", out_q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  // Engine model: echoes the accepted sample 10 cycles later, frozen by ce
  initial begin
    int            cnt;
    logic [DW-1:0] hold;
    cnt = 0;
    hold = '0;
    eng_rvalid = 1'b0;
    eng_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cnt = 0;
        eng_rvalid = 1'b0;
      end else if (ce) begin
        eng_rvalid = 1'b0;
        if (spur_req != spur_done) begin
          spur_done = spur_req;
          eng_rvalid = 1'b1;
          eng_rdata = 16'hdead;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            eng_rvalid = 1'b1;
            eng_rdata = hold;
          end
        end
        if (eng_tvalid && eng_tready && !eng_mute) begin
          cnt = 10;
          hold = eng_tdata;
        end
      end
    end
  end

  // Monitor: grants and results compared against the scoreboard queues
  initial begin
    int               g;
    logic [CW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && ce && s_tready != '0) begin
        if (grant_q.size() == 0) check("grant_unexp", s_tready, 0);
        else begin
          g = grant_q.pop_front();
          check("grant", s_tready, 32'(1) << g);
        end
      end
      if (reset_n && ce && m_tvalid && m_tready) begin
        if (out_q.size() == 0) check("out_unexp", m_tvalid, 0);
        else begin
          e = out_q.pop_front();
          check("out_dest", m_tdest, e[DW +: CW]);
          check("out_data", m_tdata, e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    int n;
    reset_n = 1'b0;
    ce = 1'b1;
    s_tvalid = '0;
    s_tdata = '0;
    eng_tready = 1'b1;
    m_tready = 1'b0;
    err_clr = 1'b0;
    repeat (3) step();

    check("rst_busy", busy, 0);
    check("rst_eng_tvalid", eng_tvalid, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_err_tmo", err_tmo, 0);
    check("rst_err_spur", err_spur, 0);
    check("rst_m_tdest", m_tdest, 0);
    reset_n = 1'b1;
    step();

    // All channels valid: round-robin 0,1,2,3 twice, data echoed
    for (int i = 0; i < NCH; i++) s_tdata[i*DW +: DW] = DW'(16'h1000 + i);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NCH; i++) push_exp(i, DW'(16'h1000 + i));
    m_tready = 1'b1;
    s_tvalid = '1;
    wait_grants(500);
    s_tvalid = '0;
    drain(200);

    // Single channel 2 with backpressure on the result
    s_tdata[2*DW +: DW] = 16'h2222;
    m_tready = 1'b0;
    push_exp(2, 16'h2222);
    s_tvalid = 4'b0100;
    n = 0;
    while (!m_tvalid && n < 100) begin step(); n++; end
    check("t2_m_tvalid_up", m_tvalid, 1);
    for (int c = 0; c < 20; c++) begin
      check("t2_hold_valid", m_tvalid, 1);
      check("t2_hold_data", m_tdata, 16'h2222);
      check("t2_hold_dest", m_tdest, 2);
      check("t2_no_ready", s_tready, 0);
      step();
    end
    push_exp(2, 16'h2222);
    m_tready = 1'b1;
    wait_grants(50);
    s_tvalid = '0;
    drain(200);

    // Engine silent: timeout after TMO cycles in WAIT
    eng_mute = 1'b1;
    s_tdata[1*DW +: DW] = 16'h3333;
    grant_q.push_back(1);
    s_tvalid = 4'b0010;
    wait_grants(50);
    s_tvalid = '0;
    check("t3_issue", eng_tvalid, 1);
    step();
    n = 0;
    while (!err_tmo && n < 3000) begin step(); n++; end
    check("t3_tmo_cycles", n, TMO);
    check("t3_busy", busy, 0);
    check("t3_m_tvalid", m_tvalid, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t3_tmo_clr", err_tmo, 0);
    eng_mute = 1'b0;

    // Spurious result while idle
    spur_req++;
    repeat (3) step();
    check("t4_spur", err_spur, 1);
    check("t4_m_tvalid", m_tvalid, 0);
    check("t4_busy", busy, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t4_spur_clr", err_spur, 0);

    // Clock enable dropped during ISSUE and during OUT
    s_tdata[3*DW +: DW] = 16'h5555;
    push_exp(3, 16'h5555);
    m_tready = 1'b0;
    s_tvalid = 4'b1000;
    step();
    ce = 1'b0;
    s_tvalid = '0;
    for (int c = 0; c < 5; c++) begin
      check("t5_iss_tvalid", eng_tvalid, 1);
      check("t5_iss_data", eng_tdata, 16'h5555);
      check("t5_iss_sel", eng_sel, 3);
      step();
    end
    ce = 1'b1;
    n = 0;
    while (!m_tvalid && n < 100) begin step(); n++; end
    check("t5_m_tvalid_up", m_tvalid, 1);
    m_tready = 1'b1;
    ce = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("t5_out_valid", m_tvalid, 1);
      check("t5_out_data", m_tdata, 16'h5555);
      step();
    end
    ce = 1'b1;
    drain(100);

    // Reset in WAIT: everything clears and channel 0 is served first again
    s_tdata[0 +: DW] = 16'h6000;
    push_exp(0, 16'h6000);
    s_tvalid = 4'b0001;
    wait_grants(50);
    s_tvalid = '0;
    drain(100);
    eng_mute = 1'b1;
    s_tdata[1*DW +: DW] = 16'h6001;
    grant_q.push_back(1);
    s_tvalid = 4'b0010;
    wait_grants(50);
    s_tvalid = '0;
    repeat (5) step();
    check("t6_busy_pre", busy, 1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_eng_tvalid", eng_tvalid, 0);
    check("t6_rst_eng_sel", eng_sel, 0);
    check("t6_rst_m_tvalid", m_tvalid, 0);
    repeat (2) step();
    reset_n = 1'b1;
    eng_mute = 1'b0;
    for (int i = 0; i < NCH; i++) s_tdata[i*DW +: DW] = DW'(16'h6100 + i);
    push_exp(0, 16'h6100);
    s_tvalid = '1;
    wait_grants(50);
    s_tvalid = '0;
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
